// File: rtl/mmm_mul_arb.sv
// Two-requester round-robin front end for one shared pipelined multiplier.
// Issues one op per cycle, tags it by requester, and routes products back in issue order.
module mmm_mul_arb #(
  parameter int unsigned IDW    = 90,
  parameter int unsigned ODW    = 181,
  parameter int unsigned LAT    = 4,
  parameter int unsigned MAXOUT = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_req0_vld,
  input  logic           i_req1_vld,
  output logic           o_req0_rdy,
  output logic           o_req1_rdy,
  input  logic [IDW-1:0] i_req0_a,
  input  logic [IDW-1:0] i_req0_b,
  input  logic [IDW-1:0] i_req1_a,
  input  logic [IDW-1:0] i_req1_b,
  output logic [IDW-1:0] o_mul_a,
  output logic [IDW-1:0] o_mul_b,
  input  logic [ODW-1:0] i_mul_res,
  output logic           o_res0_vld,
  output logic           o_res1_vld,
  output logic [ODW-1:0] o_res,
  output logic           o_busy
);

  localparam int unsigned CW = $clog2(MAXOUT + 1);

  logic [CW-1:0]  cred0, cred1;
  logic           ptr;
  logic [LAT:0]   tag_vld;
  logic [LAT:0]   tag_id;
  logic           elig0, elig1, gnt0, gnt1, issue;
  logic [IDW-1:0] sel_a, sel_b;

  // A strobe this cycle frees a credit at the same edge, so it counts as room now.
  always_comb begin
    elig0 = i_req0_vld && ((cred0 < CW'(MAXOUT)) || o_res0_vld);
    elig1 = i_req1_vld && ((cred1 < CW'(MAXOUT)) || o_res1_vld);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (!i_rst) begin
      if (elig0 && elig1) begin
        gnt0 = !ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
    issue = gnt0 || gnt1;
    sel_a = gnt1 ? i_req1_a : i_req0_a;
    sel_b = gnt1 ? i_req1_b : i_req0_b;
  end

  assign o_req0_rdy = gnt0;
  assign o_req1_rdy = gnt1;
  assign o_busy     = (|tag_vld) || o_res0_vld || o_res1_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cred0      <= '0;
      cred1      <= '0;
      ptr        <= 1'b0;
      tag_vld    <= '0;
      tag_id     <= '0;
      o_mul_a    <= '0;
      o_mul_b    <= '0;
      o_res      <= '0;
      o_res0_vld <= 1'b0;
      o_res1_vld <= 1'b0;
    end else begin
      // ptr names the requester that wins the next tie.
      if (issue) ptr <= gnt0;
      o_mul_a    <= issue ? sel_a : '0;
      o_mul_b    <= issue ? sel_b : '0;
      tag_vld    <= {tag_vld[LAT-1:0], issue};
      tag_id     <= {tag_id[LAT-1:0], gnt1};
      o_res0_vld <= tag_vld[LAT] && !tag_id[LAT];
      o_res1_vld <= tag_vld[LAT] && tag_id[LAT];
      if (tag_vld[LAT]) o_res <= i_mul_res;
      if (gnt0 && !o_res0_vld) cred0 <= cred0 + CW'(1);
      else if (!gnt0 && o_res0_vld && (cred0 != '0)) cred0 <= cred0 - CW'(1);
      if (gnt1 && !o_res1_vld) cred1 <= cred1 + CW'(1);
      else if (!gnt1 && o_res1_vld && (cred1 != '0)) cred1 <= cred1 - CW'(1);
    end
  end

endmodule

// File: tb/tb_mmm_mul_arb.sv
// Directed bench for mmm_mul_arb with a behavioural LAT-stage multiplier.
module tb_mmm_mul_arb;
  localparam int unsigned IDW = 90;
  localparam int unsigned ODW = 181;
  localparam int unsigned LAT = 4;
  localparam int unsigned MAXOUT = 4;

  logic clk = 1'b0;
  logic rst;
  logic req0_vld, req1_vld, req0_rdy, req1_rdy;
  logic [IDW-1:0] req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
  logic [ODW-1:0] mul_res, res;
  logic res0_vld, res1_vld, busy;
  logic [ODW-1:0] pipe [LAT];
  logic [ODW+1:0] exp_q [$];
  int total = 0;
  int bad = 0;

  mmm_mul_arb #(.IDW(IDW), .ODW(ODW), .LAT(LAT), .MAXOUT(MAXOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_vld(req0_vld), .i_req1_vld(req1_vld),
    .o_req0_rdy(req0_rdy), .o_req1_rdy(req1_rdy),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req1_a(req1_a), .i_req1_b(req1_b),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .i_mul_res(mul_res),
    .o_res0_vld(res0_vld), .o_res1_vld(res1_vld), .o_res(res), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: product appears LAT cycles after its operands.
  always @(posedge clk) begin
    pipe[0] <= ODW'(mul_a) * ODW'(mul_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_res = pipe[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IDW-1:0] rnd();
    return IDW'({$urandom, $urandom, $urandom});
  endfunction

  function automatic logic [ODW-1:0] prod(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
    return ODW'(a) * ODW'(b);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_vld = 1'b1; req1_vld = 1'b1;
    req0_a = 1; req0_b = 2; req1_a = 3; req1_b = 4;
    step();
    step();
    total++;
    if ({req0_rdy, req1_rdy} !== 2'b00) begin
      bad++; $display("FAIL reset_rdy: got %b%b want 00", req0_rdy, req1_rdy);
    end
    total++;
    if ({mul_a, mul_b} !== '0) begin
      bad++; $display("FAIL reset_mul: got a=%h b=%h want 0", mul_a, mul_b);
    end
    total++;
    if ({res, res0_vld, res1_vld, busy} !== '0) begin
      bad++; $display("FAIL reset_out: got res=%h v0=%b v1=%b busy=%b want 0", res, res0_vld, res1_vld, busy);
    end
    rst = 1'b0; req0_vld = 1'b0; req1_vld = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    req0_vld = 1'b1; req0_a = 3; req0_b = 5;
    #1;
    total++;
    if ({req0_rdy, req1_rdy} !== 2'b10) begin
      bad++; $display("FAIL single_rdy: got %b%b want 10", req0_rdy, req1_rdy);
    end
    step();
    req0_vld = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      total++;
      if ({res0_vld, res1_vld} !== {(k == 6), 1'b0}) begin
        bad++; $display("FAIL single_vld k=%0d: got %b%b want %b0", k, res0_vld, res1_vld, (k == 6));
      end
      total++;
      if (busy !== (k <= 6)) begin
        bad++; $display("FAIL single_busy k=%0d: got %b want %b", k, busy, (k <= 6));
      end
      if (k == 1) begin
        total++;
        if (mul_a !== IDW'(3) || mul_b !== IDW'(5)) begin
          bad++; $display("FAIL single_issue: got a=%0d b=%0d want 3 5", mul_a, mul_b);
        end
      end
      if (k == 2) begin
        total++;
        if (mul_a !== '0 || mul_b !== '0) begin
          bad++; $display("FAIL single_idle_mul: got a=%0d b=%0d want 0 0", mul_a, mul_b);
        end
      end
      if (k == 6 || k == 8) begin
        total++;
        if (res !== ODW'(15)) begin
          bad++; $display("FAIL single_res k=%0d: got %0d want 15", k, res);
        end
      end
      step();
    end
  endtask

  task automatic test_contention();
    logic [ODW+1:0] want;
    logic [IDW-1:0] a0, b0, a1, b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (res0_vld || res1_vld) begin
        total++;
        if (exp_q.size() == 0) want = '0; else want = exp_q.pop_front();
        if ({res1_vld, res0_vld, res} !== want) begin
          bad++; $display("FAIL cont_res i=%0d: got %b%b %h want %b%b %h", i, res1_vld, res0_vld, res, want[ODW+1], want[ODW], want[ODW-1:0]);
        end
      end
      if (i < 8) begin
        a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        req0_vld = 1'b1; req1_vld = 1'b1;
      end else begin
        req0_vld = 1'b0; req1_vld = 1'b0;
      end
      #1;
      if (i < 8) begin
        total++;
        if ({req0_rdy, req1_rdy} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL cont_grant i=%0d: got %b%b", i, req0_rdy, req1_rdy);
        end
        if (i % 2 == 0) exp_q.push_back({2'b01, prod(a0, b0)});
        else exp_q.push_back({2'b10, prod(a1, b1)});
      end
      step();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL cont_drain: got %0d missing results want 0", exp_q.size());
    end
  endtask

  task automatic test_credit();
    logic [ODW+1:0] want;
    logic [IDW-1:0] a0, b0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (res0_vld || res1_vld) begin
        total++;
        if (exp_q.size() == 0) want = '0; else want = exp_q.pop_front();
        if ({res1_vld, res0_vld, res} !== want) begin
          bad++; $display("FAIL cred_res i=%0d: got %b%b %h want %b%b %h", i, res1_vld, res0_vld, res, want[ODW+1], want[ODW], want[ODW-1:0]);
        end
      end
      a0 = rnd(); b0 = rnd();
      req0_a = a0; req0_b = b0;
      req0_vld = (i < 14);
      #1;
      if (i < 14) begin
        total++;
        if ({req0_rdy, req1_rdy} !== {((i % 6) < 4), 1'b0}) begin
          bad++; $display("FAIL cred_rdy i=%0d: got %b%b want %b0", i, req0_rdy, req1_rdy, ((i % 6) < 4));
        end
        if ((i % 6) < 4) exp_q.push_back({2'b01, prod(a0, b0)});
      end
      if (i == 6) begin
        total++;
        if (res0_vld !== 1'b1) begin
          bad++; $display("FAIL cred_resume: got strobe %b want 1 with rdy", res0_vld);
        end
      end
      step();
    end
    req0_vld = 1'b0;
    total++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL cred_drain: got %0d missing busy=%b want 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [ODW+1:0] want;
    logic [IDW-1:0] a0, b0, a1, b1;
    int n_ok;
    do_reset();
    n_ok = 0;
    for (int i = 0; i < 10012; i++) begin
      if (res0_vld || res1_vld) begin
        total++;
        if (exp_q.size() == 0) want = '0; else want = exp_q.pop_front();
        if ({res1_vld, res0_vld, res} !== want) begin
          bad++; $display("FAIL b2b_res i=%0d: got %b%b %h want %b%b %h", i, res1_vld, res0_vld, res, want[ODW+1], want[ODW], want[ODW-1:0]);
        end else n_ok++;
      end
      if (i % 16 == 5) begin
        a0 = '1; b0 = '1; a1 = '1; b1 = rnd();
      end else begin
        a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
      end
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      req0_vld = (i < 10000); req1_vld = (i < 10000);
      #1;
      if (i < 10000) begin
        total++;
        if ({req0_rdy, req1_rdy} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL b2b_grant i=%0d: got %b%b", i, req0_rdy, req1_rdy);
        end
        if (i % 2 == 0) exp_q.push_back({2'b01, prod(a0, b0)});
        else exp_q.push_back({2'b10, prod(a1, b1)});
      end
      step();
    end
    total++;
    if (n_ok != 10000 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_count: got %0d good left=%0d want 10000 0", n_ok, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n_res;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req0_vld = 1'b1; req0_a = IDW'(i + 2); req0_b = 7;
      #1;
      total++;
      if (req0_rdy !== 1'b1) begin
        bad++; $display("FAIL mid_issue i=%0d: got %b want 1", i, req0_rdy);
      end
      step();
    end
    req0_vld = 1'b1; req1_vld = 1'b1; rst = 1'b1;
    #1;
    total++;
    if ({req0_rdy, req1_rdy} !== 2'b00) begin
      bad++; $display("FAIL mid_rst_rdy: got %b%b want 00", req0_rdy, req1_rdy);
    end
    step();
    rst = 1'b0;
    total++;
    if ({busy, res0_vld, res1_vld} !== 3'b000 || res !== '0) begin
      bad++; $display("FAIL mid_clear: got busy=%b v=%b%b res=%h want 0", busy, res0_vld, res1_vld, res);
    end
    #1;
    total++;
    if ({req0_rdy, req1_rdy} !== 2'b10) begin
      bad++; $display("FAIL mid_first_grant: got %b%b want 10", req0_rdy, req1_rdy);
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      total++;
      if ({res0_vld, res1_vld, busy} !== 3'b000) begin
        bad++; $display("FAIL mid_quiet k=%0d: got v=%b%b busy=%b want 0", k, res0_vld, res1_vld, busy);
      end
      step();
    end
    // Exactly MAXOUT accepts before a stall proves credits restarted from zero.
    req0_a = 9; req0_b = 11;
    for (int i = 0; i < 5; i++) begin
      req0_vld = 1'b1;
      #1;
      total++;
      if (req0_rdy !== (i < 4)) begin
        bad++; $display("FAIL mid_credit i=%0d: got %b want %b", i, req0_rdy, (i < 4));
      end
      step();
    end
    req0_vld = 1'b0;
    n_res = 0;
    for (int k = 0; k < 8; k++) begin
      if (res0_vld || res1_vld) begin
        total++;
        if ({res1_vld, res0_vld, res} !== {2'b01, ODW'(99)}) begin
          bad++; $display("FAIL mid_res k=%0d: got %b%b %0d want 01 99", k, res1_vld, res0_vld, res);
        end
        n_res++;
      end
      step();
    end
    total++;
    if (n_res != 4) begin
      bad++; $display("FAIL mid_count: got %0d want 4", n_res);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_vld = 1'b0; req1_vld = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_single();
    test_contention();
    test_credit();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmm_mul_arb.md
MMM_MUL_ARB -- requirements
Module: mmm_mul_arb

Interface
- REQ-001 SHALL have parameter IDW, default 90: operand width.
- REQ-002 SHALL have parameter ODW, default 181: product width carried to requesters.
- REQ-003 SHALL have parameter LAT, default 4: fixed multiplier latency, cycles from o_mul_a/o_mul_b to matching i_mul_res; LAT >= 1.
- REQ-004 SHALL have parameter MAXOUT, default 4: max outstanding ops per requester; MAXOUT >= 1.
- REQ-005 SHALL have port i_clk, input, 1: single clock, all logic on rising edge.
- REQ-006 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
- REQ-007 SHALL have ports i_req0_vld / i_req1_vld, input, 1: requester k presents an operation.
- REQ-008 SHALL have ports o_req0_rdy / o_req1_rdy, output, 1: operation accepted this cycle when vld && rdy.
- REQ-009 SHALL have ports i_req0_a, i_req0_b, i_req1_a, i_req1_b, input, IDW: operands.
- REQ-010 SHALL have ports o_mul_a / o_mul_b, output, IDW, registered: operands to the shared pipelined multiplier.
- REQ-011 SHALL have port i_mul_res, input, ODW: multiplier product.
- REQ-012 SHALL have ports o_res0_vld / o_res1_vld, output, 1, registered: one-cycle result strobe per requester.
- REQ-013 SHALL have port o_res, output, ODW, registered: product, valid when either o_resk_vld is high.
- REQ-014 SHALL have port o_busy, output, 1: high while any operation is in flight.

Function
- REQ-015 SHALL mark requester k eligible when i_reqk_vld=1 and its credit counter < MAXOUT.
- REQ-016 SHALL grant at most one requester per cycle; o_reqk_rdy=1 only for the granted requester, combinational from vld and state.
- REQ-017 SHALL grant round-robin when both are eligible: the requester not granted most recently wins; priority pointer updates only on a grant; after reset, requester 0 has priority.
- REQ-018 SHALL grant the sole eligible requester regardless of pointer.
- REQ-019 SHALL, on accept at edge t, drive operands on o_mul_a/o_mul_b during cycle t+1; o_mul_a/o_mul_b SHALL be 0 in cycles with no issue.
- REQ-020 SHALL carry a (valid, id) tag through a LAT+1-stage shift register aligned so the tag exits in the cycle i_mul_res holds that op's product.
- REQ-021 SHALL register i_mul_res into o_res and assert o_resk_vld for the tag's id one cycle later: accept at edge t -> o_resk_vld high during cycle t+LAT+2 (t+6 at LAT=4).
- REQ-022 SHALL return results in issue order, one per cycle max, with no backpressure; sustained throughput one op per cycle.
- REQ-023 SHALL increment credit k on accept, decrement on o_resk_vld; both in same cycle -> unchanged; counter never exceeds MAXOUT nor underflows.
- REQ-024 SHALL hold o_res at its last value when no strobe is active.
- REQ-025 SHALL assert o_busy when any tag stage is valid or any result strobe is pending.
- REQ-026 SHALL ignore requester operand changes while rdy=0; operands sampled only at accept.

Reset
- REQ-027 SHALL, when i_rst=1 at an edge, clear credits, tags, pointer (to requester 0), o_mul_a, o_mul_b, o_res to 0, o_res0_vld, o_res1_vld, o_busy to 0.
- REQ-028 SHALL force o_req0_rdy=o_req1_rdy=0 while i_rst=1.
- REQ-029 SHALL discard in-flight operations on mid-operation reset; no result strobe for them after reset deasserts.

Verification
- REQ-030 Single op: req0 a=3, b=5 accepted at edge t, behavioural multiplier LAT=4 -> o_res0_vld=1, o_res=15 only during cycle t+6; o_res1_vld stays 0.
- REQ-031 Contention: both vld held high 8 cycles, random operands -> grants alternate 0,1,0,1...; each product equals a*b and is routed to the issuing requester in issue order.
- REQ-032 Credit limit: MAXOUT=4, req0 vld held high, req1 idle -> 4 accepts in cycles t..t+3, rdy0=0 until first result strobe, then accepts resume that cycle.
- REQ-033 Simultaneous accept and retire on same requester -> credit unchanged; 10000 random back-to-back ops all match a*b (including a,b up to 2^90-1).
- REQ-034 Reset mid-flight: 3 ops issued, i_rst pulsed 1 cycle at t+2 -> no o_resk_vld afterward, credits 0, o_busy=0, first post-reset grant goes to requester 0.
